// File: rtl/serial_add_pkg.sv
// Shared types and constants for the nibble-serial adder.
package serial_add_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/four_bit_RCA.sv
// 4-bit ripple-carry adder: the single slice reused every ADD cycle.
module four_bit_RCA (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [4:0] c;

    assign c[0] = cin;

    // Full-adder chain, bit 0 first.
    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[4];

endmodule

// File: rtl/serial_nibble_adder.sv
// Nibble-serial adder: one 4-bit slice per cycle, carry held in a register
// between slices, valid/ready handshakes on both sides.
module serial_nibble_adder
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 16  // multiple of 4, at least 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf,
    output logic             busy
);
    localparam int NIB  = WIDTH / NIBBLE_W;
    localparam int IDXW = $clog2(NIB);
    // Bit offset of the current nibble: idx * 4 is idx with two zero LSBs.
    localparam int BW   = IDXW + 2;
    localparam logic [IDXW-1:0] LAST = IDXW'(NIB - 1);

    state_e           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;

    logic [BW-1:0]    base;
    logic [3:0]       slice_s;
    logic             slice_c;

    assign base = {idx_q, 2'b00};

    four_bit_RCA u_slice (
        .a    (a_q[base +: NIBBLE_W]),
        .b    (b_q[base +: NIBBLE_W]),
        .cin  (c_q),
        .s    (slice_s),
        .cout (slice_c)
    );

    // State and datapath registers; reset clears everything so an aborted
    // partial sum can never surface.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            c_q     <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            c_q     <= c_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
        end
    end

    // Next-state: load on accept, one slice per ADD cycle, hold in DONE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        c_d     = c_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    c_d     = Cin;
                    idx_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                s_d[base +: NIBBLE_W] = slice_s;
                c_d = slice_c;
                if (idx_q == LAST) begin
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs come from registers only; they keep their last values in IDLE.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign S         = s_q;
    assign Cout      = c_q;
    assign Ovf       = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (s_q[WIDTH-1] != a_q[WIDTH-1]);

endmodule

// File: tb/tb_serial_nibble_adder.sv
// Scoreboard bench for serial_nibble_adder: the driver pushes accepted
// operand sets, the monitor pops and checks against plain arithmetic.
module tb_serial_nibble_adder;
    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 0;
    logic             rst = 1;
    logic             in_valid = 0;
    logic             in_ready;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic             Cin = 0;
    logic             out_valid;
    logic             out_ready = 0;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             Ovf;
    logic             busy;

    serial_nibble_adder #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Cin(Cin), .out_valid(out_valid), .out_ready(out_ready),
        .S(S), .Cout(Cout), .Ovf(Ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        int               acc;
    } op_t;

    op_t sb[$];
    int  n_cmp = 0;
    int  n_err = 0;
    logic bp_hold = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Present an operand set and keep it up until accepted.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
        int guard = 0;
        @(posedge clk); #1;
        A = a; B = b; Cin = c; in_valid = 1;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        else sb.push_back('{a: a, b: b, cin: c, acc: cyc + 1});
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    // Monitor: drives out_ready and checks every result against the model.
    logic             prev_ov = 0;
    logic             expect_idle = 0;
    int               hold = 0;
    logic [WIDTH-1:0] last_s;
    logic             last_c, last_o;

    always @(negedge clk) begin
        if (rst) begin
            prev_ov = 0; expect_idle = 0; hold = 0; out_ready = 0;
        end else begin
            if (expect_idle) begin
                chk("idle_in_ready", in_ready, 1);
                chk("idle_out_valid", out_valid, 0);
                chk("idle_busy", busy, 0);
                expect_idle = 0;
            end
            if (out_valid) begin
                if (!prev_ov) begin
                    if (sb.size() == 0) chk("spurious_out_valid", 1, 0);
                    else chk("latency", cyc - sb[0].acc, NIB);
                    hold = bp_hold ? 3 : 0;
                end else begin
                    chk("hold_S", S, last_s);
                    chk("hold_Cout", Cout, last_c);
                    chk("hold_Ovf", Ovf, last_o);
                end
                chk("done_in_ready", in_ready, 0);
                chk("done_busy", busy, 1);
                if (hold > 0) begin
                    out_ready = 0;
                    hold--;
                end else begin
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                last_s = S; last_c = Cout; last_o = Ovf;
                if (out_ready && sb.size() > 0) begin
                    op_t    o;
                    logic [WIDTH:0] full;
                    longint sv;
                    logic   eovf;
                    o    = sb.pop_front();
                    full = {1'b0, o.a} + {1'b0, o.b} + {{WIDTH{1'b0}}, o.cin};
                    sv   = longint'($signed(o.a)) + longint'($signed(o.b)) + longint'(o.cin);
                    eovf = (sv > ((longint'(1) << (WIDTH-1)) - 1)) || (sv < -(longint'(1) << (WIDTH-1)));
                    chk("sum_S", S, full[WIDTH-1:0]);
                    chk("sum_Cout", Cout, full[WIDTH]);
                    chk("sum_Ovf", Ovf, eovf);
                    expect_idle = 1;
                end
                prev_ov = !out_ready;
            end else begin
                out_ready = $urandom_range(0, 1);
                prev_ov   = 0;
            end
        end
    end

    initial begin
        int guard;
        // Reset: outputs checked while reset is still asserted.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_S", S, 0);
        chk("rst_Cout", Cout, 0);
        chk("rst_Ovf", Ovf, 0);
        chk("rst_busy", busy, 0);
        rst = 0;

        // Directed vectors.
        send(16'h1234, 16'h4321, 1'b0); idle();
        send(16'hFFFF, 16'h0001, 1'b0); idle();
        send(16'h7FFF, 16'h0000, 1'b1); idle();

        // Backpressure: result held for at least 3 cycles.
        bp_hold = 1;
        send(16'h8000, 16'h8000, 1'b0); idle();
        send(16'hABCD, 16'h1111, 1'b1); idle();
        repeat (12) @(posedge clk);
        #1 bp_hold = 0;

        // in_valid held high with fresh operands during ADD/DONE.
        send(16'h0F0F, 16'hF0F1, 1'b0);
        send(16'h1111, 16'h2222, 1'b1);
        send(16'h7000, 16'h1000, 1'b0);
        idle();

        // Random operands, mix of back-to-back and gaps.
        for (int i = 0; i < 60; i++) begin
            send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
            if ($urandom_range(0, 2) == 0) idle();
        end
        idle();

        // Drain before the abort test.
        guard = 0;
        while (sb.size() != 0 && guard < 2000) begin
            @(posedge clk);
            guard++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
        repeat (3) @(posedge clk);

        // Abort at idx=2: no result may ever appear.
        send(16'hAAAA, 16'h5555, 1'b0);
        idle();                       // accept edge; now in ADD with idx=0
        @(posedge clk);               // idx=1
        @(posedge clk);               // idx=2
        #1 rst = 1;
        void'(sb.pop_back());
        @(posedge clk);
        #1 rst = 0;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_S", S, 0);
        chk("abort_Cout", Cout, 0);
        chk("abort_Ovf", Ovf, 0);
        chk("abort_busy", busy, 0);
        repeat (10) @(posedge clk);

        // One more operation after the abort.
        send(16'h0001, 16'h0002, 1'b1); idle();
        guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        if (sb.size() != 0) chk("final_drain_timeout", sb.size(), 0);
        repeat (4) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
